adaptive_threshold_scanner: RTL

Downstream consumer of the middle RAM image buffer (8-bit pixels, col/row addressed, 1-cycle read latency).
On iStart it raster-scans a WIDTH x HEIGHT image and fetches each pixel's 3x3 neighbourhood through the middle RAM read port.
For each pixel it emits a binary adaptive-threshold result (local mean minus offset) on a valid/ready stream, with coordinates, to the output/display stage.

---
 rtl/adaptive_threshold_scanner.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/adaptive_threshold_scanner.sv
// Raster-scanning 3x3 local-mean adaptive thresholder reading the middle RAM image buffer.
// Optional macro ATS_ZERO_BORDER_EN: out-of-image taps contribute 0 instead of the replicated edge pixel.
module adaptive_threshold_scanner #(
   parameter int unsigned WIDTH    = 128,
   parameter int unsigned HEIGHT   = 128,
   parameter int unsigned C_OFFSET = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       iStart,
   output logic       oBusy,
   output logic       oDone,
   output logic [7:0] oRdcol,
   output logic [7:0] oRdrow,
   input  logic [7:0] iRddata,
   output logic       oValid,
   input  logic       iReady,
   output logic [7:0] oCol,
   output logic [7:0] oRow,
   output logic       oBin
);

   localparam int          XMAX  = int'(WIDTH) - 1;
   localparam int          YMAX  = int'(HEIGHT) - 1;
   localparam logic [7:0]  XLAST = 8'(WIDTH - 1);
   localparam logic [7:0]  YLAST = 8'(HEIGHT - 1);
   localparam logic [12:0] OFS9  = 13'(9 * C_OFFSET);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LAST,
      OUT,
      DONE
   } state_t;

   state_t      state, stateNext;
   logic [3:0]  k, kNext;
   logic [12:0] sum, sumNext, sumFinal;
   logic [7:0]  x, y, xNext, yNext;
   logic [7:0]  centre, centreNext;
   logic [7:0]  rdColNext, rdRowNext;
   logic        validNext, binNext;
   logic [7:0]  colNext, rowNext;
   logic [7:0]  ax, ay;
   logic [3:0]  ak;
   logic [7:0]  addrCol, addrRow;
   logic        addrLoad;
   logic [12:0] dataTerm;
   logic [12:0] lhs;

`ifdef ATS_ZERO_BORDER_EN
   // tapOob tracks the address on the bus; dataOob lines up with its returning data.
   logic addrOob, tapOob, tapOobNext, dataOob;
`endif

   // Neighbour address for tap ak around (ax, ay), clamped onto the image.
   always_comb begin
      int tk, cx, cy;
      tk = int'(ak);
      cx = int'(ax) + (tk % 3) - 1;
      cy = int'(ay) + (tk / 3) - 1;
`ifdef ATS_ZERO_BORDER_EN
      addrOob = (cx < 0) || (cx > XMAX) || (cy < 0) || (cy > YMAX);
`endif
      if (cx < 0)
         cx = 0;
      else if (cx > XMAX)
         cx = XMAX;
      if (cy < 0)
         cy = 0;
      else if (cy > YMAX)
         cy = YMAX;
      addrCol = 8'(cx);
      addrRow = 8'(cy);
   end

`ifdef ATS_ZERO_BORDER_EN
   assign dataTerm = dataOob ? '0 : {5'b0, iRddata};
`else
   assign dataTerm = {5'b0, iRddata};
`endif

   assign sumFinal = sum + dataTerm;
   assign lhs      = 13'(9) * {5'b0, centre} + OFS9;
   assign oBusy    = (state != IDLE);
   assign oDone    = (state == DONE);

   always_comb begin
      stateNext  = state;
      kNext      = k;
      sumNext    = sum;
      xNext      = x;
      yNext      = y;
      centreNext = centre;
      validNext  = oValid;
      binNext    = oBin;
      colNext    = oCol;
      rowNext    = oRow;
      addrLoad   = 1'b0;
      ax         = x;
      ay         = y;
      ak         = k;

      case (state)
         IDLE: begin
            if (iStart) begin
               stateNext = READ;
               xNext     = '0;
               yNext     = '0;
               kNext     = '0;
               sumNext   = '0;
               addrLoad  = 1'b1;
               ax        = '0;
               ay        = '0;
               ak        = '0;
            end
         end

         READ: begin
            if (k != 4'd0)
               sumNext = sumFinal;
            if (k == 4'd5)
               centreNext = iRddata;
            if (k == 4'd8) begin
               stateNext = LAST;
            end else begin
               kNext    = k + 4'd1;
               addrLoad = 1'b1;
               ak       = k + 4'd1;
            end
         end

         LAST: begin
            sumNext   = sumFinal;
            binNext   = (lhs > sumFinal);
            colNext   = x;
            rowNext   = y;
            validNext = 1'b1;
            stateNext = OUT;
         end

         OUT: begin
            if (iReady) begin
               validNext = 1'b0;
               if (x == XLAST) begin
                  xNext = '0;
                  yNext = (y == YLAST) ? '0 : y + 8'd1;
               end else begin
                  xNext = x + 8'd1;
               end
               if (x == XLAST && y == YLAST) begin
                  stateNext = DONE;
               end else begin
                  stateNext = READ;
                  kNext     = '0;
                  sumNext   = '0;
                  addrLoad  = 1'b1;
                  ax        = xNext;
                  ay        = yNext;
                  ak        = '0;
               end
            end
         end

         DONE: stateNext = IDLE;

         default: stateNext = IDLE;
      endcase

      rdColNext = addrLoad ? addrCol : oRdcol;
      rdRowNext = addrLoad ? addrRow : oRdrow;
`ifdef ATS_ZERO_BORDER_EN
      tapOobNext = addrLoad ? addrOob : tapOob;
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         k      <= '0;
         sum    <= '0;
         x      <= '0;
         y      <= '0;
         centre <= '0;
         oRdcol <= '0;
         oRdrow <= '0;
         oValid <= 1'b0;
         oBin   <= 1'b0;
         oCol   <= '0;
         oRow   <= '0;
      end else begin
         state  <= stateNext;
         k      <= kNext;
         sum    <= sumNext;
         x      <= xNext;
         y      <= yNext;
         centre <= centreNext;
         oRdcol <= rdColNext;
         oRdrow <= rdRowNext;
         oValid <= validNext;
         oBin   <= binNext;
         oCol   <= colNext;
         oRow   <= rowNext;
      end
   end

`ifdef ATS_ZERO_BORDER_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tapOob  <= 1'b0;
         dataOob <= 1'b0;
      end else begin
         tapOob  <= tapOobNext;
         dataOob <= tapOob;
      end
   end
`endif

endmodule
